// File: rtl/aes128_rkey_buffer_pkg.sv
// Shared AES-128 round-key types and constants.
// The ZERO state only exists when AES128_RKEY_ZEROIZE_EN is defined.
package aes128_pkg;

    localparam int         AES128_NUM_RKEYS  = 11;
    localparam logic [3:0] AES128_LAST_ROUND = 4'd10;

    typedef logic [127:0] aes128_word128_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2
`ifdef AES128_RKEY_ZEROIZE_EN
        ,
        ST_ZERO   = 2'd3
`endif
    } rkey_state_t;

    function automatic logic idx_valid(input logic [3:0] idx);
        return idx <= AES128_LAST_ROUND;
    endfunction

endpackage

// File: rtl/aes128_rkey_buffer_if.sv
// Host, expansion-stage and read-port signals of the round-key buffer.
// key_zero is present only when AES128_RKEY_ZEROIZE_EN is defined.
interface aes128_rkey_buffer_if;
    import aes128_pkg::*;

    logic            key_load;
    aes128_word128_t key_in;
    logic            key_busy;
    logic            key_ready;
    aes128_word128_t exp_cipher_key;
    logic [3:0]      exp_round_num;
    logic            exp_rkey_en;
    aes128_word128_t exp_round_key;
    logic            rd_en;
    logic [3:0]      rd_idx;
    aes128_word128_t rd_key;
    logic            rd_valid;
    logic            rd_err;
`ifdef AES128_RKEY_ZEROIZE_EN
    logic            key_zero;
`endif

    modport slave (
        input  key_load, key_in, exp_round_key, rd_en, rd_idx,
`ifdef AES128_RKEY_ZEROIZE_EN
        input  key_zero,
`endif
        output key_busy, key_ready, exp_cipher_key, exp_round_num, exp_rkey_en,
        output rd_key, rd_valid, rd_err
    );

    modport master (
        output key_load, key_in, exp_round_key, rd_en, rd_idx,
`ifdef AES128_RKEY_ZEROIZE_EN
        output key_zero,
`endif
        input  key_busy, key_ready, exp_cipher_key, exp_round_num, exp_rkey_en,
        input  rd_key, rd_valid, rd_err
    );

endinterface

// File: rtl/aes128_rkey_regfile.sv
// 11 x 128-bit round-key store: one write port, one registered read port.
// Entry 0 is also exposed directly as the expansion stage's cipher key.
module aes128_rkey_regfile
    import aes128_pkg::*;
(
    input  logic            clk_sys,
    input  logic            rst,
    input  logic            we,
    input  logic [3:0]      waddr,
    input  aes128_word128_t wdata,
    input  logic            re_i,
    input  logic            rd_ok_i,
    input  logic [3:0]      raddr_i,
    output aes128_word128_t rdata_o,
    output aes128_word128_t entry0_o
);

    aes128_word128_t mem_q [AES128_NUM_RKEYS];
    aes128_word128_t rdata_q, rdata_d;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AES128_NUM_RKEYS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && idx_valid(waddr)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // A rejected read still updates the port, returning zero.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = (rd_ok_i && idx_valid(raddr_i)) ? mem_q[raddr_i] : '0;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign entry0_o = mem_q[0];

endmodule

// File: rtl/aes128_rkey_buffer.sv
// Round-key sequencer: steps the expansion stage through rounds 0..9, stores K0..K10, serves reads.
// Optional AES128_RKEY_ZEROIZE_EN adds key_zero, which wipes the store in 11 cycles.
module aes128_rkey_buffer
    import aes128_pkg::*;
(
    input logic                 clk_sys,
    input logic                 rst,
    aes128_rkey_buffer_if.slave bus
);

    // state  | meaning
    // IDLE   | no valid key schedule, waiting for key_load
    // EXPAND | cnt is the round being stepped; K1..K10 captured as they arrive
    // READY  | K0..K10 valid, reads served
    // ZERO   | clearing entry cnt (zeroize build only)

    rkey_state_t     state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            idle_or_ready;
    logic            load_acc, zero_acc, rd_ok;
    logic            rf_we;
    logic [3:0]      rf_waddr;
    aes128_word128_t rf_wdata;
    logic            busy, ready, rkey_en;
    logic [3:0]      round_num;
    logic            rd_valid_q, rd_err_q;
    aes128_word128_t rd_key, entry0;

    assign idle_or_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
`ifdef AES128_RKEY_ZEROIZE_EN
    assign zero_acc = idle_or_ready && bus.key_zero;
`else
    assign zero_acc = 1'b0;
`endif
    assign load_acc = idle_or_ready && bus.key_load && !zero_acc;
    assign rd_ok    = bus.rd_en && (state_q == ST_READY) && !load_acc && !zero_acc
                      && idx_valid(bus.rd_idx);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (zero_acc) begin
`ifdef AES128_RKEY_ZEROIZE_EN
                    state_d = ST_ZERO;
`endif
                    cnt_d   = '0;
                end else if (load_acc) begin
                    state_d = ST_EXPAND;
                    cnt_d   = '0;
                end
            end
            ST_EXPAND: begin
                if (cnt_q == AES128_LAST_ROUND) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef AES128_RKEY_ZEROIZE_EN
            ST_ZERO: begin
                if (cnt_q == AES128_LAST_ROUND) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // exp_* decode only from state/cnt flops so key_load never reaches the expansion stage.
    always_comb begin
        busy      = (state_q == ST_EXPAND);
`ifdef AES128_RKEY_ZEROIZE_EN
        busy      = busy || (state_q == ST_ZERO);
`endif
        ready     = (state_q == ST_READY);
        rkey_en   = (state_q == ST_EXPAND) && (cnt_q < AES128_LAST_ROUND);
        round_num = (state_q == ST_EXPAND) ? cnt_q : 4'd0;

        rf_we    = 1'b0;
        rf_waddr = cnt_q;
        rf_wdata = '0;
        if (load_acc) begin
            rf_we    = 1'b1;
            rf_waddr = 4'd0;
            rf_wdata = bus.key_in;
        end else if ((state_q == ST_EXPAND) && (cnt_q != 4'd0)) begin
            rf_we    = 1'b1;
            rf_wdata = bus.exp_round_key;
        end
`ifdef AES128_RKEY_ZEROIZE_EN
        else if (state_q == ST_ZERO) begin
            rf_we = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            rd_err_q   <= bus.rd_en && !rd_ok;
        end
    end

    aes128_rkey_regfile u_regfile (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .re_i     (bus.rd_en),
        .rd_ok_i  (rd_ok),
        .raddr_i  (bus.rd_idx),
        .rdata_o  (rd_key),
        .entry0_o (entry0)
    );

    assign bus.key_busy       = busy;
    assign bus.key_ready      = ready;
    assign bus.exp_cipher_key = entry0;
    assign bus.exp_round_num  = round_num;
    assign bus.exp_rkey_en    = rkey_en;
    assign bus.rd_key         = rd_key;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_err         = rd_err_q;

endmodule
